mono_frame_scheduler: RTL and testbench

Groups the mono samples produced by the stereo-to-mono converter into fixed-length frames for the spectrum/FFT stage. Uses a ping-pong buffer of two FRAME_LEN banks: one bank fills while the other streams out on an AXI4-Stream master with TLAST marking each frame end. Sits between the mono converter output and the FFT input, in the 100 MHz domain. Counts sent frames and samples dropped on overrun.

---
 rtl/mono_frame_scheduler.sv | 156 +++++++++++++++
 tb/tb_mono_frame_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mono_frame_scheduler.sv
// Ping-pong frame builder: mono samples fill one FRAME_LEN bank while the other
// bank streams out on an AXI4-Stream master, TLAST on the final beat of each frame.
module mono_frame_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  M_AXIS_ACLK,
  input  logic                  M_AXIS_ARESETN,
  input  logic                  enable,
  input  logic                  mono_sample_valid,
  input  logic [DATA_WIDTH-1:0] mono_sample,
  output logic                  M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frames_sent,
  output logic [CNT_WIDTH-1:0]  dropped_samples
);

  localparam int IDX_W = $clog2(FRAME_LEN);

  // Handshake: a beat transfers on a rising edge where M_AXIS_TVALID && M_AXIS_TREADY;
  // once TVALID is high, TDATA/TLAST hold until that transfer and TVALID stays high
  // until the TLAST beat has transferred.
  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state_q;
  logic                  wr_bank_q;
  logic                  rd_bank_q;
  logic [IDX_W-1:0]      wr_idx_q;
  logic [IDX_W:0]        rd_idx_q;
  logic [1:0]            bank_full_q;
  logic [1:0]            bank_full_d;
  logic                  s1_valid_q;
  logic                  s1_last_q;
  logic                  tvalid_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tlast_q;
  logic                  busy_q;
  logic [CNT_WIDTH-1:0]  frames_q;
  logic [CNT_WIDTH-1:0]  dropped_q;

  logic [DATA_WIDTH-1:0] mem_q [0:2*FRAME_LEN-1];
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic             wr_hit;
  logic             wr_en;
  logic             wr_drop;
  logic             wr_last;
  logic             adv;
  logic             start;
  logic             issue;
  logic             rd_en;
  logic [IDX_W:0]   rd_addr;
  logic             release_frame;

  always_comb begin
    wr_hit        = enable && mono_sample_valid;
    wr_en         = wr_hit && !bank_full_q[wr_bank_q];
    wr_drop       = wr_hit && bank_full_q[wr_bank_q];
    wr_last       = wr_en && (wr_idx_q == IDX_W'(FRAME_LEN - 1));
    adv           = !tvalid_q || M_AXIS_TREADY;
    start         = (state_q == IDLE) && bank_full_q[rd_bank_q];
    // rd_idx_q MSB set means every address of the frame has been issued.
    issue         = (state_q == STREAM) && adv && !rd_idx_q[IDX_W];
    rd_en         = start || issue;
    rd_addr       = {rd_bank_q, issue ? rd_idx_q[IDX_W-1:0] : {IDX_W{1'b0}}};
    release_frame = (state_q == STREAM) && tvalid_q && M_AXIS_TREADY && tlast_q;
    bank_full_d   = bank_full_q;
    if (release_frame) bank_full_d[rd_bank_q] = 1'b0;
    if (wr_last)       bank_full_d[wr_bank_q] = 1'b1;
  end

  // Buffer storage: no reset so it maps onto block RAM with a registered read port.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (wr_en) mem_q[{wr_bank_q, wr_idx_q}] <= mono_sample;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q     <= IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      bank_full_q <= 2'b00;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      frames_q    <= '0;
      dropped_q   <= '0;
    end else begin
      bank_full_q <= bank_full_d;

      if (!enable) begin
        wr_idx_q <= '0;
      end else if (wr_en) begin
        wr_idx_q <= wr_last ? '0 : wr_idx_q + 1'b1;
        if (wr_last) wr_bank_q <= ~wr_bank_q;
      end

      if (wr_drop && (dropped_q != {CNT_WIDTH{1'b1}})) dropped_q <= dropped_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= STREAM;
            busy_q     <= 1'b1;
            s1_valid_q <= 1'b1;
            s1_last_q  <= 1'b0;
            rd_idx_q   <= (IDX_W+1)'(1);
          end
        end
        STREAM: begin
          // Two-stage pipe: s1 holds the RAM read, the output register holds the beat.
          if (adv) begin
            tvalid_q <= s1_valid_q;
            tlast_q  <= s1_last_q;
            if (s1_valid_q) tdata_q <= rd_data_q;
            if (issue) begin
              s1_valid_q <= 1'b1;
              s1_last_q  <= (rd_idx_q == (IDX_W+1)'(FRAME_LEN - 1));
              rd_idx_q   <= rd_idx_q + 1'b1;
            end else begin
              s1_valid_q <= 1'b0;
              s1_last_q  <= 1'b0;
            end
          end
          if (release_frame) begin
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            rd_bank_q <= ~rd_bank_q;
            frames_q  <= frames_q + 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign M_AXIS_TVALID   = tvalid_q;
  assign M_AXIS_TDATA    = tdata_q;
  assign M_AXIS_TLAST    = tlast_q;
  assign busy            = busy_q;
  assign frames_sent     = frames_q;
  assign dropped_samples = dropped_q;

endmodule

// File: tb/tb_mono_frame_scheduler.sv
// Directed bench for mono_frame_scheduler with FRAME_LEN=8: latency, ordering,
// backpressure, overrun drops, enable abandonment and mid-frame reset.
module tb_mono_frame_scheduler;

  localparam int DW = 32;
  localparam int FL = 8;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          mono_sample_valid;
  logic [DW-1:0] mono_sample;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tready;
  logic          busy;
  logic [CW-1:0] frames_sent;
  logic [CW-1:0] dropped_samples;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  mono_frame_scheduler #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .CNT_WIDTH(CW)) dut (
    .M_AXIS_ACLK      (clk),
    .M_AXIS_ARESETN   (rst_n),
    .enable           (enable),
    .mono_sample_valid(mono_sample_valid),
    .mono_sample      (mono_sample),
    .M_AXIS_TVALID    (m_tvalid),
    .M_AXIS_TDATA     (m_tdata),
    .M_AXIS_TLAST     (m_tlast),
    .M_AXIS_TREADY    (m_tready),
    .busy             (busy),
    .frames_sent      (frames_sent),
    .dropped_samples  (dropped_samples)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver
  task automatic send(input logic [DW-1:0] v);
    mono_sample_valid = 1'b1;
    mono_sample       = v;
    tick();
    mono_sample_valid = 1'b0;
  endtask

  task automatic push_range(input int first, input int last);
    for (int v = first; v <= last; v++) exp_q.push_back(DW'(v));
  endtask

  // Consume one frame from the stream; mode 0 keeps TREADY high, mode 1 toggles 1,0,0.
  task automatic collect_frame(input string tag, input int mode);
    int beat = 0;
    int cyc  = 0;
    logic held = 1'b0;
    logic [DW-1:0] hd = '0;
    logic hl = 1'b0;
    logic [DW-1:0] e;
    while (beat < FL && cyc < 200) begin
      m_tready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (held) begin
        check({tag, "_stall_data"}, m_tdata, hd);
        check({tag, "_stall_last"}, DW'(m_tlast), DW'(hl));
        check({tag, "_stall_valid"}, DW'(m_tvalid), 1);
        held = 1'b0;
      end
      if (m_tvalid) begin
        if (m_tready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          check({tag, "_data"}, m_tdata, e);
          check({tag, "_last"}, DW'(m_tlast), DW'(beat == FL - 1));
          beat++;
        end else begin
          held = 1'b1;
          hd   = m_tdata;
          hl   = m_tlast;
        end
      end else if (beat > 0) begin
        check({tag, "_tvalid_gap"}, DW'(m_tvalid), 1);
      end
      tick();
      cyc++;
    end
    check({tag, "_beats"}, DW'(beat), DW'(FL));
    check({tag, "_tvalid_after"}, DW'(m_tvalid), 0);
  endtask

  initial begin
    int cyc;
    int accepted;
    rst_n = 1'b0;
    enable = 1'b0;
    mono_sample_valid = 1'b0;
    mono_sample = '0;
    m_tready = 1'b0;
    #12;

    // 1: reset state
    do_reset();
    check("rst_tvalid", DW'(m_tvalid), 0);
    check("rst_tlast", DW'(m_tlast), 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_busy", DW'(busy), 0);
    check("rst_frames", DW'(frames_sent), 0);
    check("rst_dropped", DW'(dropped_samples), 0);

    // 2: one frame, slow writes, TREADY high; TVALID rises two edges after last write
    enable = 1'b1;
    m_tready = 1'b1;
    for (int v = 1; v <= FL; v++) begin
      send(DW'(v));
      if (v < FL) begin tick(); tick(); end
    end
    check("lat_n0_tvalid", DW'(m_tvalid), 0);
    check("lat_n0_busy", DW'(busy), 0);
    tick();
    check("lat_n1_tvalid", DW'(m_tvalid), 0);
    check("lat_n1_busy", DW'(busy), 1);
    tick();
    check("lat_n2_tvalid", DW'(m_tvalid), 1);
    check("lat_n2_tdata", m_tdata, 1);
    push_range(1, FL);
    collect_frame("t2", 0);
    check("t2_busy", DW'(busy), 0);
    check("t2_frames", DW'(frames_sent), 1);

    // 3: same frame under TREADY toggling
    do_reset();
    enable = 1'b1;
    m_tready = 1'b0;
    for (int v = 1; v <= FL; v++) send(DW'(v));
    tick();
    tick();
    check("t3_hold_tvalid", DW'(m_tvalid), 1);
    push_range(1, FL);
    collect_frame("t3", 1);
    check("t3_frames", DW'(frames_sent), 1);

    // 4: both banks fill while stalled, third frame dropped, then drain both
    do_reset();
    enable = 1'b1;
    m_tready = 1'b0;
    for (int v = 1; v <= 3 * FL; v++) send(DW'(v));
    check("t4_dropped", DW'(dropped_samples), 8);
    check("t4_busy", DW'(busy), 1);
    check("t4_hold_data", m_tdata, 1);
    push_range(1, FL);
    collect_frame("t4a", 0);
    push_range(FL + 1, 2 * FL);
    collect_frame("t4b", 0);
    check("t4_frames", DW'(frames_sent), 2);
    check("t4_dropped_end", DW'(dropped_samples), 8);

    // 5: partial frame abandoned by dropping enable
    do_reset();
    enable = 1'b1;
    m_tready = 1'b1;
    send(100);
    send(101);
    send(102);
    enable = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    for (int v = 1; v <= FL; v++) send(DW'(v));
    push_range(1, FL);
    collect_frame("t5", 0);
    check("t5_dropped", DW'(dropped_samples), 0);
    check("t5_frames", DW'(frames_sent), 1);
    cyc = 0;
    while (cyc < 12 && !m_tvalid) begin tick(); cyc++; end
    check("t5_no_stray_frame", DW'(m_tvalid), 0);

    // 6: reset asserted while beat 4 is on the bus
    do_reset();
    enable = 1'b1;
    m_tready = 1'b0;
    for (int v = 1; v <= FL; v++) send(DW'(v));
    tick();
    tick();
    m_tready = 1'b1;
    accepted = 0;
    cyc = 0;
    while (accepted < 3 && cyc < 50) begin
      if (m_tvalid) accepted++;
      tick();
      cyc++;
    end
    check("t6_beat4_valid", DW'(m_tvalid), 1);
    check("t6_beat4_data", m_tdata, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_tvalid", DW'(m_tvalid), 0);
    check("t6_rst_tdata", m_tdata, 0);
    check("t6_rst_busy", DW'(busy), 0);
    check("t6_rst_frames", DW'(frames_sent), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_post_tvalid", DW'(m_tvalid), 0);
    for (int v = 11; v < 11 + FL; v++) send(DW'(v));
    push_range(11, 10 + FL);
    collect_frame("t6", 0);
    check("t6_frames", DW'(frames_sent), 1);
    cyc = 0;
    while (cyc < 12 && !m_tvalid) begin tick(); cyc++; end
    check("t6_no_resume", DW'(m_tvalid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
